iic_cfg_seq: RTL and testbench

- Table-driven I2C configuration sequencer for the HDMI transceiver pair (MS72xx RX/TX).
- Walks a synchronous ROM of command entries and drives the existing I2C byte driver (pluse/w_r/addr/data_in, busy/data_out) one transaction per entry.
- Supports timed delays between entries, single-register reads and end-of-table.
- Sits between the power-up reset logic and the I2C driver; asserts done when the chips are configured.

---
 rtl/iic_cfg_seq.sv | 203 ++++++++++++++++++++
 tb/tb_iic_cfg_seq.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_cfg_seq.sv
// Table-driven I2C configuration sequencer: walks a command ROM and drives the I2C byte driver.
// Optional feature macro CFG_READBACK_VERIFY_EN: read back and compare every WRITE entry.
module iic_cfg_seq #(
    parameter int          CLK_FRE     = 50_000_000,
    parameter int          TBL_AW      = 8,
    parameter logic [7:0]  DEV_ID0     = 8'hB2,
    parameter logic [7:0]  DEV_ID1     = 8'h56,
    parameter logic [15:0] BUSY_TO     = 16'd4096,
    parameter logic [15:0] INIT_DLY_MS = 16'd10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [18:0]       tbl_data,
    output logic              iic_pluse,
    output logic [7:0]        iic_device_id,
    output logic              iic_w_r,
    output logic [3:0]        iic_byte_len,
    output logic [7:0]        iic_addr,
    output logic [7:0]        iic_data_in,
    input  logic              iic_busy,
    input  logic [7:0]        iic_data_out,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    output logic              done,
    output logic              error,
    output logic [TBL_AW-1:0] err_idx
);

    // state     | meaning
    // IDLE      | after reset, waiting for start
    // INIT_WAIT | settle delay before the first fetch
    // FETCH     | ROM read latency
    // DECODE    | latch entry fields, dispatch on opcode
    // ISSUE     | raise iic_pluse, arm busy timeout
    // WAIT_H    | wait for driver to accept (busy high)
    // WAIT_L    | wait for frame end (busy low)
    // DELAY     | count programmed milliseconds
    // NEXT      | advance table index
    // DONE      | END entry reached
    // ERR       | busy timeout or readback mismatch
    typedef enum logic [3:0] {
        IDLE, INIT_WAIT, FETCH, DECODE, ISSUE, WAIT_H, WAIT_L, DELAY, NEXT, DONE, ERR
    } state_t;

    localparam logic [1:0]  OP_WRITE = 2'b00;
    localparam logic [1:0]  OP_DELAY = 2'b01;
    localparam logic [1:0]  OP_END   = 2'b11;
    localparam logic [31:0] TICK_MAX = 32'(CLK_FRE / 1000 - 1);

    state_t      state, state_nxt;
    logic [31:0] tick_cnt;
    logic        tick;
    logic [15:0] dly_rem;
    logic [15:0] to_cnt;

`ifdef CFG_READBACK_VERIFY_EN
    logic vfy;
    logic vfy_bad;
    assign vfy_bad = vfy && (iic_data_out != iic_data_in);
`endif

    assign tick         = (tick_cnt == '0);
    assign iic_byte_len = 4'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = INIT_WAIT;
            INIT_WAIT:       if (dly_rem == '0) state_nxt = FETCH;
            FETCH:           state_nxt = DECODE;
            DECODE: begin
                case (tbl_data[18:17])
                    OP_END:   state_nxt = DONE;
                    OP_DELAY: state_nxt = DELAY;
                    default:  state_nxt = ISSUE;
                endcase
            end
            ISSUE:           state_nxt = WAIT_H;
            WAIT_H: begin
                if (iic_busy)           state_nxt = WAIT_L;
                else if (to_cnt == '0)  state_nxt = ERR;
            end
            WAIT_L: begin
                if (!iic_busy) begin
`ifdef CFG_READBACK_VERIFY_EN
                    if (vfy_bad)               state_nxt = ERR;
                    else if (!vfy && iic_w_r)  state_nxt = ISSUE;
                    else                       state_nxt = NEXT;
`else
                    state_nxt = NEXT;
`endif
                end
            end
            DELAY:           if (dly_rem == '0) state_nxt = NEXT;
            NEXT:            state_nxt = (&tbl_addr) ? DONE : FETCH;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            tbl_addr      <= '0;
            iic_pluse     <= 1'b0;
            iic_device_id <= 8'd0;
            iic_w_r       <= 1'b1;
            iic_addr      <= 8'd0;
            iic_data_in   <= 8'd0;
            rd_valid      <= 1'b0;
            rd_data       <= 8'd0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_idx       <= '0;
            tick_cnt      <= '0;
            dly_rem       <= '0;
            to_cnt        <= '0;
`ifdef CFG_READBACK_VERIFY_EN
            vfy           <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            rd_valid <= 1'b0;
            tick_cnt <= tick ? TICK_MAX : tick_cnt - 32'd1;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        tbl_addr <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        dly_rem  <= INIT_DLY_MS;
                        tick_cnt <= TICK_MAX;
`ifdef CFG_READBACK_VERIFY_EN
                        vfy      <= 1'b0;
`endif
                    end
                end
                INIT_WAIT, DELAY: begin
                    if (tick && dly_rem != '0) dly_rem <= dly_rem - 16'd1;
                end
                DECODE: begin
                    // Delay length is loaded unconditionally; it only matters for DELAY entries.
                    dly_rem  <= tbl_data[15:0];
                    tick_cnt <= TICK_MAX;
                    if (!tbl_data[17]) begin
                        iic_device_id <= tbl_data[16] ? DEV_ID1 : DEV_ID0;
                        iic_w_r       <= (tbl_data[18:17] == OP_WRITE);
                        iic_addr      <= tbl_data[15:8];
                        iic_data_in   <= tbl_data[7:0];
                    end
                    if (tbl_data[18:17] == OP_END) done <= 1'b1;
                end
                ISSUE: begin
                    iic_pluse <= 1'b1;
                    to_cnt    <= BUSY_TO - 16'd1;
                end
                WAIT_H: begin
                    if (iic_busy) begin
                        iic_pluse <= 1'b0;
                    end else if (to_cnt == '0) begin
                        iic_pluse <= 1'b0;
                        error     <= 1'b1;
                        err_idx   <= tbl_addr;
                    end else begin
                        to_cnt <= to_cnt - 16'd1;
                    end
                end
                WAIT_L: begin
                    if (!iic_busy) begin
`ifdef CFG_READBACK_VERIFY_EN
                        if (vfy) begin
                            vfy <= 1'b0;
                            if (vfy_bad) begin
                                error   <= 1'b1;
                                err_idx <= tbl_addr;
                            end
                        end else if (iic_w_r) begin
                            vfy     <= 1'b1;
                            iic_w_r <= 1'b0;
                        end else begin
                            rd_data  <= iic_data_out;
                            rd_valid <= 1'b1;
                        end
`else
                        if (!iic_w_r) begin
                            rd_data  <= iic_data_out;
                            rd_valid <= 1'b1;
                        end
`endif
                    end
                end
                NEXT: begin
                    // Last table slot ends the run rather than wrapping to entry 0.
                    if (&tbl_addr) done <= 1'b1;
                    else           tbl_addr <= tbl_addr + TBL_AW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Bench for iic_cfg_seq: table programs walked by a reference model, a behavioural I2C
// driver, and a monitor that pops expected transactions / read results from queues.
module tb_iic_cfg_seq;

    localparam int TICK    = 20;
    localparam int INIT_MS = 2;
    localparam int BUSY_TO = 64;
    localparam logic [18:0] E_END = 19'h60000;

    typedef struct {
        logic [7:0] dev;
        logic       w_r;
        logic [7:0] addr;
        logic [7:0] data;
        int         lo;
        int         hi;
        bit         first;
    } txn_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  tbl_addr;
    logic [18:0] tbl_data;
    logic        iic_pluse;
    logic [7:0]  iic_device_id;
    logic        iic_w_r;
    logic [3:0]  iic_byte_len;
    logic [7:0]  iic_addr;
    logic [7:0]  iic_data_in;
    logic        iic_busy;
    logic [7:0]  iic_data_out;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        done;
    logic        error;
    logic [7:0]  err_idx;

    logic [18:0] rom [256];
    txn_t        exp_txn_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  drv_rd_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int t_fall   = 0;
    int t_pluse  = 0;
    int t_end    = 0;
    int exp_end  = 0;
    int drv_served = 0;
    int drv_limit  = 1 << 30;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    iic_cfg_seq #(
        .CLK_FRE(TICK * 1000), .TBL_AW(8), .DEV_ID0(8'hB2), .DEV_ID1(8'h56),
        .BUSY_TO(16'(BUSY_TO)), .INIT_DLY_MS(16'(INIT_MS))
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .iic_pluse(iic_pluse), .iic_device_id(iic_device_id), .iic_w_r(iic_w_r),
        .iic_byte_len(iic_byte_len), .iic_addr(iic_addr), .iic_data_in(iic_data_in),
        .iic_busy(iic_busy), .iic_data_out(iic_data_out), .rd_valid(rd_valid),
        .rd_data(rd_data), .done(done), .error(error), .err_idx(err_idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [18:0] ent(input logic [1:0] op, input logic d,
                                        input logic [7:0] r, input logic [7:0] v);
        return {op, d, r, v};
    endfunction

    function automatic logic [18:0] dly(input int ms);
        return {2'b01, 1'b0, 16'(ms)};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = E_END;
    endtask

    // Reference model: walk the table, list the frames the chips should see and the reads
    // that should be reported, and the ms of delay preceding each frame.
    task automatic model();
        txn_t        t;
        logic [18:0] e;
        logic [7:0]  v;
        int          ms;
        int          ndly;
        bit          first;
        ms = INIT_MS; ndly = 0; first = 1'b1;
        for (int i = 0; i < 256; i++) begin
            e = rom[i];
            case (e[18:17])
                2'b11: begin exp_end = i; return; end
                2'b01: begin ms += int'(e[15:0]); ndly++; end
                default: begin
                    t.dev   = e[16] ? 8'h56 : 8'hB2;
                    t.w_r   = (e[18:17] == 2'b00);
                    t.addr  = e[15:8];
                    t.data  = e[7:0];
                    t.lo    = ms * TICK;
                    t.hi    = ms * TICK + TICK + 4 * ndly;
                    t.first = first;
                    exp_txn_q.push_back(t);
                    first = 1'b0; ms = 0; ndly = 0;
                    if (!t.w_r) begin
                        v = 8'($urandom);
                        drv_rd_q.push_back(v);
                        exp_rd_q.push_back(v);
                    end
`ifdef CFG_READBACK_VERIFY_EN
                    else begin
                        t.w_r = 1'b0; t.lo = 0; t.hi = TICK; t.first = 1'b0;
                        exp_txn_q.push_back(t);
                        drv_rd_q.push_back(e[7:0]);
                    end
`endif
                end
            endcase
        end
        exp_end = 255;
    endtask

    // Behavioural I2C driver: answers each pluse rise with a busy frame of random length.
    initial begin
        bit rd;
        iic_busy = 1'b0;
        iic_data_out = 8'd0;
        forever begin
            @(negedge clk);
            if (iic_pluse && drv_served < drv_limit) begin
                drv_served++;
                rd = !iic_w_r;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                iic_busy = 1'b1;
                repeat ($urandom_range(3, 8)) @(negedge clk);
                if (rd) iic_data_out = (drv_rd_q.size() > 0) ? drv_rd_q.pop_front() : 8'($urandom);
                iic_busy = 1'b0;
                t_fall = cyc;
            end
        end
    end

    // Monitor / scoreboard
    logic mon_prev = 1'b0;
    txn_t mon_t;
    initial begin
        forever begin
            @(negedge clk);
            if (iic_pluse && !mon_prev) begin
                if (exp_txn_q.size() == 0) begin
                    fail_now("unexpected_txn", $sformatf("frame to %0h/%0h, required none", iic_device_id, iic_addr));
                end else begin
                    mon_t = exp_txn_q.pop_front();
                    check("txn_dev", 32'(iic_device_id), 32'(mon_t.dev));
                    check("txn_w_r", 32'(iic_w_r), 32'(mon_t.w_r));
                    check("txn_addr", 32'(iic_addr), 32'(mon_t.addr));
                    if (mon_t.w_r) check("txn_data", 32'(iic_data_in), 32'(mon_t.data));
                    check("txn_len", 32'(iic_byte_len), 32'd1);
                    check_range("txn_gap", cyc - (mon_t.first ? t_start : t_fall), mon_t.lo, mon_t.hi);
                end
                t_pluse = cyc;
            end
            if (rd_valid) begin
                if (exp_rd_q.size() == 0) fail_now("unexpected_rd", $sformatf("rd_valid with %0h, required no pulse", rd_data));
                else check("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
            end
            mon_prev = iic_pluse;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle limit reached, required test end");
        $fatal(1, "watchdog");
    end

    task automatic flush_q();
        exp_txn_q.delete();
        exp_rd_q.delete();
        drv_rd_q.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_tbl_addr", 32'(tbl_addr), 32'd0);
        check("rst_pluse", 32'(iic_pluse), 32'd0);
        check("rst_w_r", 32'(iic_w_r), 32'd1);
        check("rst_dev", 32'(iic_device_id), 32'd0);
        check("rst_addr", 32'(iic_addr), 32'd0);
        check("rst_data_in", 32'(iic_data_in), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_idx", 32'(err_idx), 32'd0);
    endtask

    task automatic run_table(input int budget, input bit exp_err, input int exp_idx, input bit spurious);
        bit ok;
        @(negedge clk);
        start = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        if (spurious) begin
            repeat (28) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || error) begin ok = 1'b1; break; end
        end
        t_end = cyc;
        if (!ok) fail_now("run_timeout", "neither done nor error within budget");
        check("done", 32'(done), 32'(!exp_err));
        check("error", 32'(error), 32'(exp_err));
        check("pluse_idle", 32'(iic_pluse), 32'd0);
        if (exp_err) begin
            check("err_idx", 32'(err_idx), 32'(exp_idx));
        end else begin
            check("end_tbl_addr", 32'(tbl_addr), 32'(exp_end));
            check("txn_left", 32'(exp_txn_q.size()), 32'd0);
            check("rd_left", 32'(exp_rd_q.size()), 32'd0);
        end
        flush_q();
    endtask

    initial begin
        bit ok;
        int n;
        clear_rom();
        rstn = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rstn = 1'b1;

        // single write
        rom[0] = ent(2'b00, 1'b0, 8'h12, 8'h5A);
        model();
        run_table(500, 1'b0, 0, 1'b0);

        // delay then write to the second device
        clear_rom();
        rom[0] = dly(3);
        rom[1] = ent(2'b00, 1'b1, 8'h01, 8'h80);
        model();
        run_table(500, 1'b0, 0, 1'b0);

        // single read returning A3
        clear_rom();
        rom[0] = ent(2'b10, 1'b0, 8'h00, 8'h00);
        model();
        drv_rd_q[0] = 8'hA3;
        exp_rd_q[0] = 8'hA3;
        run_table(500, 1'b0, 0, 1'b0);

        // driver never answers: timeout at entry 0, then a clean restart
        clear_rom();
        rom[0] = ent(2'b00, 1'b0, 8'h20, 8'h11);
        model();
        drv_limit = drv_served;
        run_table(500, 1'b1, 0, 1'b0);
        check_range("busy_to_cycles", t_end - t_pluse, BUSY_TO - 1, BUSY_TO + 1);
        drv_limit = 1 << 30;
        model();
        run_table(500, 1'b0, 0, 1'b0);

        // timeout on the third entry
        clear_rom();
        rom[0] = ent(2'b00, 1'b1, 8'h30, 8'h31);
        rom[1] = ent(2'b10, 1'b0, 8'h32, 8'h00);
        rom[2] = ent(2'b00, 1'b0, 8'h34, 8'h35);
        model();
        drv_limit = drv_served + 2;
        run_table(1000, 1'b1, 2, 1'b0);
        drv_limit = 1 << 30;

        // random programs
        for (int r = 0; r < 8; r++) begin
            clear_rom();
            n = $urandom_range(2, 6);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0, 1:    rom[i] = ent(2'b00, 1'($urandom), 8'($urandom), 8'($urandom));
                    2:       rom[i] = ent(2'b10, 1'($urandom), 8'($urandom), 8'($urandom));
                    default: rom[i] = dly($urandom_range(0, 3));
                endcase
            end
            model();
            run_table(3000, 1'b0, 0, r[0]);
        end

        // full table with no END: stops at the last slot without wrapping
        for (int i = 0; i < 256; i++) rom[i] = dly(0);
        model();
        run_table(3000, 1'b0, 0, 1'b0);

        // reset while waiting for the frame to end
        clear_rom();
        rom[0] = ent(2'b00, 1'b1, 8'h33, 8'h44);
        model();
        @(negedge clk);
        start = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (iic_busy && !iic_pluse) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("reach_wait_l", "busy frame not seen");
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        rstn = 1'b1;
        for (int i = 0; i < 50 && iic_busy; i++) @(negedge clk);
        flush_q();
        model();
        run_table(500, 1'b0, 0, 1'b0);

`ifdef CFG_READBACK_VERIFY_EN
        clear_rom();
        rom[0] = ent(2'b00, 1'b0, 8'h12, 8'h5A);
        model();
        drv_rd_q[0] = 8'h5B;
        run_table(500, 1'b1, 0, 1'b0);
        model();
        run_table(500, 1'b0, 0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
